// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register; drives combinational IM and latches its word.
// Optional FETCH_ADEL_CHECK_EN enables fetch address-error detection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] ISR_PC    = 32'h0000_4180,
  parameter logic [31:0] IM_BYTES  = 32'h0000_2000,
  parameter logic        IM_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        int_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  output logic        im_enable,
  input  logic [31:0] im_result,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_adel
);
  localparam logic [31:0] IM_END = RESET_PC + IM_BYTES;
  logic [31:0] pc;
  logic        adel;
  assign im_addr   = pc;
  assign im_enable = reset ? ~IM_ENABLE : IM_ENABLE;
`ifdef FETCH_ADEL_CHECK_EN
  logic in_range, in_isr;
  assign in_range = (pc >= RESET_PC) && (pc < IM_END);
  assign in_isr   = (pc >= ISR_PC) && (pc < IM_END);
  assign adel     = ((|pc[1:0]) || !in_range) && !in_isr;
`else
  assign adel = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_instr <= 32'd0;
      id_pc    <= RESET_PC;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (int_req || eret) begin
      pc       <= int_req ? ISR_PC : epc;
      id_instr <= 32'd0;
      id_pc    <= pc;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (!stall) begin
      // redirect keeps the current word as the delay slot
      pc       <= redirect_en ? redirect_pc : pc + 32'd4;
      id_instr <= adel ? 32'd0 : im_result;
      id_pc    <= pc;
      id_valid <= 1'b1;
      id_adel  <= adel;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a combinational IM model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_en, int_req, eret;
  logic [31:0] redirect_pc, epc, im_addr, im_result, id_instr, id_pc;
  logic        im_enable, id_valid, id_adel;
  int compared = 0;
  int mismatched = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .int_req(int_req), .eret(eret), .epc(epc),
    .im_addr(im_addr), .im_enable(im_enable), .im_result(im_result),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h3000) ? 32'h2401_0001 : {16'hA5C0, w[15:0]};
  endfunction

  assign im_result = im_word(im_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; stall = 0; redirect_en = 0; redirect_pc = 0; int_req = 0; eret = 0; epc = 0;
    tick;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_en", {31'd0, im_enable}, 32'd0);
    chk("rst_pc", im_addr, 32'h3000);
    chk("rst_idpc", id_pc, 32'h3000);
    chk("rst_instr", id_instr, 32'd0);
    tick;
    chk("rst2_valid", {31'd0, id_valid}, 32'd0);
    reset = 0;
    #1 chk("run_en", {31'd0, im_enable}, 32'd1);
    tick;
    chk("f0_pc", id_pc, 32'h3000);
    chk("f0_instr", id_instr, 32'h2401_0001);
    chk("f0_valid", {31'd0, id_valid}, 32'd1);
    chk("f0_addr", im_addr, 32'h3004);
    tick;
    chk("f1_pc", id_pc, 32'h3004);
    chk("f1_instr", id_instr, 32'hA5C0_3004);
    redirect_en = 1; redirect_pc = 32'h3100;
    tick;
    chk("ds_pc", id_pc, 32'h3008);
    chk("ds_valid", {31'd0, id_valid}, 32'd1);
    chk("rd_addr", im_addr, 32'h3100);
    redirect_en = 0;
    tick;
    chk("rd_idpc", id_pc, 32'h3100);
    chk("rd_addr2", im_addr, 32'h3104);
    stall = 1; redirect_en = 1; redirect_pc = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("st_addr", im_addr, 32'h3104);
      chk("st_idpc", id_pc, 32'h3100);
      chk("st_instr", id_instr, 32'hA5C0_3100);
    end
    stall = 0;
    tick;
    chk("st_rd_addr", im_addr, 32'h3200);
    chk("st_rd_idpc", id_pc, 32'h3104);
    redirect_en = 0;
    tick;
    chk("st_rd_idpc2", id_pc, 32'h3200);
    int_req = 1; stall = 1; eret = 1; epc = 32'h3010;
    tick;
    chk("int_addr", im_addr, 32'h4180);
    chk("int_valid", {31'd0, id_valid}, 32'd0);
    chk("int_instr", id_instr, 32'd0);
    chk("int_idpc", id_pc, 32'h3204);
    int_req = 0; stall = 0; eret = 0;
    tick;
    chk("isr_idpc", id_pc, 32'h4180);
    chk("isr_valid", {31'd0, id_valid}, 32'd1);
    chk("isr_adel", {31'd0, id_adel}, 32'd0);
    eret = 1;
    tick;
    chk("eret_addr", im_addr, 32'h3010);
    chk("eret_valid", {31'd0, id_valid}, 32'd0);
    eret = 0;
    tick;
    chk("eret_idpc", id_pc, 32'h3010);
    chk("eret_valid2", {31'd0, id_valid}, 32'd1);
    chk("eret_instr", id_instr, 32'hA5C0_3010);
    redirect_en = 1; redirect_pc = 32'h3002;
    tick;
    chk("mis_addr", im_addr, 32'h3002);
    redirect_en = 0;
    tick;
    chk("mis_idpc", id_pc, 32'h3002);
    chk("mis_valid", {31'd0, id_valid}, 32'd1);
`ifdef FETCH_ADEL_CHECK_EN
    chk("mis_adel", {31'd0, id_adel}, 32'd1);
    chk("mis_instr", id_instr, 32'd0);
`else
    chk("mis_adel", {31'd0, id_adel}, 32'd0);
    chk("mis_instr", id_instr, 32'h2401_0001);
`endif
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_en = 0;
    tick;
    chk("wrap_addr", im_addr, 32'h0000_0000);
`ifdef FETCH_ADEL_CHECK_EN
    chk("oor_adel", {31'd0, id_adel}, 32'd1);
`else
    chk("oor_adel", {31'd0, id_adel}, 32'd0);
`endif
    reset = 1; int_req = 1; stall = 1; redirect_en = 1;
    tick;
    chk("mid_rst_addr", im_addr, 32'h3000);
    chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("mid_rst_idpc", id_pc, 32'h3000);
    chk("mid_rst_en", {31'd0, im_enable}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
